// File: rtl/mem_loader_if.sv
// mem_loader_if -- RAM write port driven by the serial loader.
//   we    : one-cycle write strobe
//   addr  : 16-bit word address of the write
//   din   : 16-bit write data, held between strobes
// Modports: master (loader side, drives the port), slave (RAM side).
interface mem_loader_if;
  logic        we;
  logic [15:0] addr;
  logic [15:0] din;

  modport master (output we, addr, din);
  modport slave  (input  we, addr, din);
endinterface

// File: rtl/mem_loader.sv
// mem_loader -- receives UART bytes, pairs them big-endian into 16-bit
// words and writes them to consecutive RAM addresses starting at 0.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (4..65535)
//   MAX_WORDS    : words per load session (1..65535)
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous active-low reset
//   rx        : asynchronous serial input, idle high, LSB first
//   load_en   : session enable; low clears position, flags and any frame
//   mem       : RAM write port (we / addr / din), master modport
//   busy      : high while a frame is being received or written
//   done      : high once MAX_WORDS words have been written
//   frame_err : sticky framing (stop bit) or parity error
// Build option:
//   LOADER_PARITY_EN : frames carry an even-parity bit after bit 7
module mem_loader #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int MAX_WORDS    = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic          load_en,
  mem_loader_if.master  mem,
  output logic          busy,
  output logic          done,
  output logic          frame_err
);

  localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] CNT_BIT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] ADDR_MAX = 16'(MAX_WORDS - 1);

`ifdef LOADER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WRITE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE} state_t;
`endif

  state_t      state_reg, state_next;
  logic [1:0]  sync_reg;
  logic        rx_sync;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  hi_reg, hi_next;
  logic        phase_low_reg, phase_low_next;   // 0: expecting high byte
  logic [15:0] addr_reg, addr_next;
  logic [15:0] din_reg, din_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        frame_bad;
`ifdef LOADER_PARITY_EN
  logic        par_bad_reg, par_bad_next;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) sync_reg <= 2'b11;
    else        sync_reg <= {sync_reg[0], rx};
  end
  assign rx_sync = sync_reg[1];

`ifdef LOADER_PARITY_EN
  // A parity mismatch is reported at the stop bit so the frame is still
  // consumed completely and its trailing bits are not taken as a new start.
  assign frame_bad = !rx_sync || par_bad_reg;
`else
  assign frame_bad = !rx_sync;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      hi_reg        <= '0;
      phase_low_reg <= 1'b0;
      addr_reg      <= '0;
      din_reg       <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
`ifdef LOADER_PARITY_EN
      par_bad_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      hi_reg        <= hi_next;
      phase_low_reg <= phase_low_next;
      addr_reg      <= addr_next;
      din_reg       <= din_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
`ifdef LOADER_PARITY_EN
      par_bad_reg   <= par_bad_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    hi_next        = hi_reg;
    phase_low_next = phase_low_reg;
    addr_next      = addr_reg;
    din_next       = din_reg;
    done_next      = done_reg;
    err_next       = err_reg;
`ifdef LOADER_PARITY_EN
    par_bad_next   = par_bad_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (!rx_sync && !done_reg) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        // Half a bit in: a low line confirms a real start bit.
        if (cnt_reg == CNT_HALF) begin
          cnt_next = '0;
          if (rx_sync) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            bit_next   = '0;
`ifdef LOADER_PARITY_EN
            par_bad_next = 1'b0;
`endif
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      DATA: begin
        if (cnt_reg == CNT_BIT) begin
          cnt_next   = '0;
          shift_next = {rx_sync, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef LOADER_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
`ifdef LOADER_PARITY_EN
      PARITY: begin
        if (cnt_reg == CNT_BIT) begin
          cnt_next     = '0;
          par_bad_next = ^{shift_reg, rx_sync};
          state_next   = STOP;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_reg == CNT_BIT) begin
          cnt_next = '0;
          if (frame_bad) begin
            err_next       = 1'b1;
            phase_low_next = 1'b0;
            state_next     = IDLE;
          end else if (!phase_low_reg) begin
            hi_next        = shift_reg;
            phase_low_next = 1'b1;
            state_next     = IDLE;
          end else begin
            din_next       = {hi_reg, shift_reg};
            phase_low_next = 1'b0;
            state_next     = WRITE;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      WRITE: begin
        state_next = IDLE;
        // The last address is held so addr never wraps.
        if (addr_reg == ADDR_MAX) done_next = 1'b1;
        else                      addr_next = addr_reg + 16'd1;
      end
      default: state_next = IDLE;
    endcase

    // Session abort overrides everything except reset.
    if (!load_en) begin
      state_next     = IDLE;
      addr_next      = '0;
      phase_low_next = 1'b0;
      done_next      = 1'b0;
      err_next       = 1'b0;
    end
  end

  assign mem.we    = (state_reg == WRITE);
  assign mem.addr  = addr_reg;
  assign mem.din   = din_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign frame_err = err_reg;

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;
  localparam int CPB = 4;
  localparam int MW  = 4;
  localparam int GAP = 12;
`ifdef LOADER_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic load_en = 1'b0;
  logic busy, done, frame_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_cycles = 0;
  int busy_cycles = 0;
  logic [15:0] cap_addr[$];
  logic [15:0] cap_din[$];
  int          cap_cyc[$];

  mem_loader_if bus();

  mem_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .rx(rx), .load_en(load_en),
    .mem(bus), .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (bus.we === 1'b1) begin
      we_cycles++;
      cap_addr.push_back(bus.addr);
      cap_din.push_back(bus.din);
      cap_cyc.push_back(cyc);
      $display("write addr=%h din=%h", bus.addr, bus.din);
    end
  end

  task automatic clear_capture();
    we_cycles = 0;
    cap_addr.delete();
    cap_din.delete();
    cap_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef LOADER_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (CPB) @(negedge clk);
`else
    if (par_flip) $display("note: parity flip ignored, parity disabled");
`endif
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (GAP) @(negedge clk);
    $display("sent byte %h stop=%b", d, stop_bit);
  endtask

  task automatic pulse_load_en();
    @(negedge clk) load_en = 1'b0;
    @(negedge clk) load_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.we); end
    checks++; if (bus.addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", bus.addr); end
    checks++; if (bus.din !== 16'h0000) begin errors++; $display("FAIL reset_din: got %h want 0000", bus.din); end
    checks++; if ({busy, done, frame_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, frame_err}); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_pair();
    int t0;
    clear_capture();
    send_byte(8'h12, 1'b1, 1'b0);
    t0 = cyc;
    send_byte(8'h34, 1'b1, 1'b0);
    checks++; if (cap_addr.size() !== 1) begin errors++; $display("FAIL pair_count: got %0d want 1", cap_addr.size()); end
    checks++; if (cap_addr[0] !== 16'h0000) begin errors++; $display("FAIL pair_addr: got %h want 0000", cap_addr[0]); end
    checks++; if (cap_din[0] !== 16'h1234) begin errors++; $display("FAIL pair_din: got %h want 1234", cap_din[0]); end
    checks++; if (cap_cyc[0] - t0 !== FRAME_BITS * CPB + 1) begin errors++; $display("FAIL pair_latency: got %0d want %0d", cap_cyc[0] - t0, FRAME_BITS * CPB + 1); end
    checks++; if (bus.addr !== 16'h0001) begin errors++; $display("FAIL pair_next_addr: got %h want 0001", bus.addr); end
  endtask

  task automatic test_abort();
    pulse_load_en();
    checks++; if (bus.addr !== 16'h0000) begin errors++; $display("FAIL abort_addr: got %h want 0000", bus.addr); end
    checks++; if (bus.din !== 16'h1234) begin errors++; $display("FAIL abort_din_hold: got %h want 1234", bus.din); end
  endtask

  task automatic test_fill();
    logic [15:0] exp_w;
    clear_capture();
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i), 1'b1, 1'b0);
    checks++; if (cap_addr.size() !== 4) begin errors++; $display("FAIL fill_count: got %0d want 4", cap_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      exp_w = {8'hA0 + 8'(2 * i), 8'hA1 + 8'(2 * i)};
      checks++; if (cap_addr[i] !== 16'(i)) begin errors++; $display("FAIL fill_addr%0d: got %h want %h", i, cap_addr[i], 16'(i)); end
      checks++; if (cap_din[i] !== exp_w) begin errors++; $display("FAIL fill_din%0d: got %h want %h", i, cap_din[i], exp_w); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL fill_done: got %b want 1", done); end
    checks++; if (bus.addr !== 16'h0003) begin errors++; $display("FAIL fill_addr_hold: got %h want 0003", bus.addr); end
    clear_capture();
    busy_cycles = 0;
    send_byte(8'hA8, 1'b1, 1'b0);
    checks++; if (we_cycles !== 0) begin errors++; $display("FAIL fill_ignored_we: got %0d want 0", we_cycles); end
    checks++; if (busy_cycles !== 0) begin errors++; $display("FAIL fill_ignored_busy: got %0d want 0", busy_cycles); end
    pulse_load_en();
    checks++; if ({done, bus.addr} !== 17'h0_0000) begin errors++; $display("FAIL fill_clear: got done=%b addr=%h want done=0 addr=0000", done, bus.addr); end
  endtask

  task automatic test_frame_err();
    clear_capture();
    send_byte(8'h55, 1'b0, 1'b0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b want 1", frame_err); end
    send_byte(8'hBE, 1'b1, 1'b0);
    send_byte(8'hEF, 1'b1, 1'b0);
    checks++; if (cap_addr.size() !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", cap_addr.size()); end
    checks++; if (cap_addr[0] !== 16'h0000) begin errors++; $display("FAIL ferr_addr: got %h want 0000", cap_addr[0]); end
    checks++; if (cap_din[0] !== 16'hBEEF) begin errors++; $display("FAIL ferr_din: got %h want beef", cap_din[0]); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b want 1", frame_err); end
    @(negedge clk) load_en = 1'b0;
    @(negedge clk) load_en = 1'b1;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
    // Rebuild addr=1 for the glitch check.
    send_byte(8'hBE, 1'b1, 1'b0);
    send_byte(8'hEF, 1'b1, 1'b0);
  endtask

  task automatic test_glitch();
    clear_capture();
    busy_cycles = 0;
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (busy_cycles !== CPB / 2) begin errors++; $display("FAIL glitch_busy: got %0d want %0d", busy_cycles, CPB / 2); end
    checks++; if (we_cycles !== 0) begin errors++; $display("FAIL glitch_we: got %0d want 0", we_cycles); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b want 0", frame_err); end
    checks++; if (bus.addr !== 16'h0001) begin errors++; $display("FAIL glitch_addr: got %h want 0001", bus.addr); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h9C;
    clear_capture();
    send_byte(8'h12, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = d[4];
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({bus.we, busy, done, frame_err} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b want 0000", {bus.we, busy, done, frame_err}); end
    checks++; if ({bus.addr, bus.din} !== 32'h0) begin errors++; $display("FAIL rst_mid_bus: got addr=%h din=%h want 0000/0000", bus.addr, bus.din); end
    reset = 1'b1;
    rx = 1'b1;
    repeat (60) @(negedge clk);
    checks++; if (we_cycles !== 0) begin errors++; $display("FAIL rst_mid_no_we: got %0d want 0", we_cycles); end
    send_byte(8'h56, 1'b1, 1'b0);
    send_byte(8'h78, 1'b1, 1'b0);
    checks++; if (cap_addr.size() !== 1) begin errors++; $display("FAIL rst_mid_count: got %0d want 1", cap_addr.size()); end
    checks++; if ({cap_addr[0], cap_din[0]} !== 32'h0000_5678) begin errors++; $display("FAIL rst_mid_write: got addr=%h din=%h want 0000/5678", cap_addr[0], cap_din[0]); end
  endtask

`ifdef LOADER_PARITY_EN
  task automatic test_parity();
    pulse_load_en();
    clear_capture();
    send_byte(8'h03, 1'b1, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL par_err: got %b want 1", frame_err); end
    pulse_load_en();
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h04, 1'b1, 1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_ok_ferr: got %b want 0", frame_err); end
    checks++; if (cap_din.size() !== 1) begin errors++; $display("FAIL par_count: got %0d want 1", cap_din.size()); end
    checks++; if (cap_din[0] !== 16'h0304) begin errors++; $display("FAIL par_din: got %h want 0304", cap_din[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_pair();
    test_abort();
    test_fill();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
`ifdef LOADER_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 10417, clock cycles per serial bit (100 MHz / 9600 baud); legal range 4..65535.
REQ-002 Parameter: MAX_WORDS, default 256, number of 16-bit words per load session; legal range 1..65535.
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: rx  input  1  asynchronous UART serial data, idle high, 8N1, LSB first.
REQ-006 Port: load_en  input  1  session enable; low aborts the session and clears position.
REQ-007 Port: we  output  1  one-cycle RAM write strobe.
REQ-008 Port: addr  output  16  RAM word address for the write.
REQ-009 Port: din  output  16  RAM write data, valid while we=1.
REQ-010 Port: busy  output  1  high while a serial frame is in progress.
REQ-011 Port: done  output  1  high once MAX_WORDS words are written.
REQ-012 Port: frame_err  output  1  sticky stop-bit or parity error flag.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-014 Receive FSM states SHALL be IDLE, START, DATA, STOP and WRITE.
REQ-015 IDLE SHALL go to START on synchronized rx=0 when load_en=1 and done=0.
REQ-016 START SHALL resample rx at CLKS_PER_BIT/2 (integer divide) cycles; rx=1 there SHALL be a glitch and return to IDLE with no side effects.
REQ-017 DATA SHALL sample 8 bits, each CLKS_PER_BIT cycles after the previous sample, shifting LSB first.
REQ-018 STOP SHALL sample once after CLKS_PER_BIT cycles; rx=0 SHALL set frame_err, discard the byte, reset the byte phase to high byte, and return to IDLE.
REQ-019 Bytes SHALL pair big-endian: the first good byte of a pair goes to din[15:8], the second to din[7:0].
REQ-020 A good second byte SHALL enter WRITE: we=1 for exactly one cycle, addr=current word index, din=assembled word; then IDLE.
REQ-021 Write latency SHALL be 1 clk from the end of the stop-bit sample cycle to we=1.
REQ-022 addr SHALL increment by 1 the cycle after each write; addr SHALL NOT wrap.
REQ-023 When the write at addr=MAX_WORDS-1 completes, done SHALL go to 1, addr SHALL hold at MAX_WORDS-1, and further frames SHALL be ignored.
REQ-024 load_en=0 SHALL, on the next clk, force IDLE, addr=0, byte phase=high, done=0, frame_err=0, we=0, abandoning any partial frame or byte.
REQ-025 busy SHALL be 1 in START, DATA, STOP and WRITE, and 0 in IDLE.
REQ-026 din SHALL hold its last written value between strobes.

Reset
REQ-027 reset=0 at a clk edge SHALL give state=IDLE, we=0, addr=0, din=0, busy=0, done=0, frame_err=0, byte phase=high, and synchronizer flops=1.
REQ-028 reset SHALL take priority over load_en and any in-progress frame; a reset asserted mid-frame SHALL produce no write.

Configuration
REQ-029 Macro LOADER_PARITY_EN defined: each frame SHALL carry an even-parity bit after bit 7, sampled in a PARITY state between DATA and STOP.
REQ-030 Under LOADER_PARITY_EN, a parity mismatch SHALL be handled exactly as a stop-bit error (REQ-018).
REQ-031 LOADER_PARITY_EN undefined: frames SHALL be 8N1 with no PARITY state and no parity logic.

Verification (bench uses CLKS_PER_BIT=4, MAX_WORDS=4, parity off unless stated)
REQ-032 Send bytes 0x12, 0x34 with load_en=1 -> single we pulse with addr=0, din=0x1234; addr=1 afterwards.
REQ-033 Send 8 bytes 0xA0..0xA7 -> four writes of 0xA0A1, 0xA2A3, 0xA4A5, 0xA6A7 at addr 0..3; done=1 after the 4th; a 9th byte produces no we.
REQ-034 Send byte 0x55 with the stop bit forced 0, then 0xBE, 0xEF -> frame_err=1 and one write of 0xBEEF at addr=0.
REQ-035 Drive a 1-cycle low glitch on rx -> no busy beyond START, no we, no frame_err.
REQ-036 Assert reset=0 during bit 4 of the second byte of a pair -> no we; all outputs at reset values next cycle; a subsequent pair writes at addr=0.
REQ-037 With LOADER_PARITY_EN, send 0x03 with parity bit 1 -> frame_err=1 and no write; the same byte with parity bit 0 is accepted.
